// File: rtl/tdm_mux_4x1.sv
// Four-channel round-robin TDM multiplexer: serialises channel words onto Y with
// their 2-bit channel index on S, behind a single registered output stage.
module tdm_mux_4x1 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [4*W-1:0] Din,
  input  logic [3:0]     Din_valid,
  output logic [3:0]     Din_ready,
  output logic [W-1:0]   Y,
  output logic [1:0]     S,
  output logic           Y_valid,
  input  logic           Y_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [1:0]     last_r;
  logic [W-1:0]   y_r;
  logic [1:0]     s_r;
  logic           load_ok_s;
  logic           grant_any_s;
  logic [1:0]     grant_idx_s;
  logic           xfer_in_s;
  logic           xfer_out_s;

  // Scan last+1 .. last+4 (mod 4); returns {found, index} of the first valid channel.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx  = last + k[1:0];
      pick = (!pick[2] && valid[idx]) ? {1'b1, idx} : pick;
    end
    return pick;
  endfunction

  // Grant arbitration and handshake qualifiers; ready is held low throughout reset.
  always_comb begin
    load_ok_s                  = (state_r == EMPTY) || Y_ready;
    {grant_any_s, grant_idx_s} = rr_pick(Din_valid, last_r);
    xfer_in_s                  = grant_any_s && load_ok_s && rst_n;
    xfer_out_s                 = (state_r == FULL) && Y_ready;
  end

  // One-hot ready toward the granted channel only.
  always_comb begin
    Din_ready = 4'b0000;
    if (xfer_in_s) begin
      Din_ready[grant_idx_s] = 1'b1;
    end else begin
      Din_ready = 4'b0000;
    end
  end

  // Next-state logic: a grant always (re)fills the register, an unreplaced drain empties it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (xfer_in_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (xfer_in_s) begin
          state_next_s = FULL;
        end else if (xfer_out_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output word, channel index and round-robin pointer; pointer 3 gives channel 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r    <= {W{1'b0}};
      s_r    <= 2'd0;
      last_r <= 2'd3;
    end else if (xfer_in_s) begin
      y_r    <= Din[grant_idx_s*W +: W];
      s_r    <= grant_idx_s;
      last_r <= grant_idx_s;
    end else begin
      y_r    <= y_r;
      s_r    <= s_r;
      last_r <= last_r;
    end
  end

  // Output decode: Y_valid is the FULL state; Y/S keep their value after a drain.
  always_comb begin
    Y       = y_r;
    S       = s_r;
    Y_valid = (state_r == FULL);
  end

endmodule

// File: tb/tb_tdm_mux_4x1.sv
// Directed self-checking bench for tdm_mux_4x1 with W = 8.
module tb_tdm_mux_4x1;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din;
  logic [3:0]  din_valid;
  logic [3:0]  din_ready;
  logic [7:0]  y;
  logic [1:0]  s;
  logic        y_valid;
  logic        y_ready;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  tdm_mux_4x1 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .Din(din), .Din_valid(din_valid), .Din_ready(din_ready),
    .Y(y), .S(s), .Y_valid(y_valid), .Y_ready(y_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = 32'h0; din_valid = 4'b0000; y_ready = 1'b0;
    #12;
    checks++;
    if ({y, s, y_valid, din_ready} !== {8'h00, 2'd0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state y=%h s=%0d yv=%b rdy=%b required 00/0/0/0000", y, s, y_valid, din_ready);
    end
    din_valid = 4'b1111;
    #1;
    checks++;
    if (din_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got %b required 0000", din_ready);
    end
    din_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({y, s, y_valid, din_ready} !== {8'h00, 2'd0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL idle_after_reset y=%h s=%0d yv=%b rdy=%b required 00/0/0/0000", y, s, y_valid, din_ready);
    end
  endtask

  task automatic test_round_robin;
    logic [7:0] ey [5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
    logic [3:0] er [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] es [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    din = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; din_valid = 4'b1111; y_ready = 1'b1;
    #1;
    checks++;
    if (din_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rr_first_ready got %b required 0001", din_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({s, y, y_valid} !== {es[k], ey[k], 1'b1}) begin
        failures++;
        $display("FAIL rr_word%0d s=%0d y=%h yv=%b required %0d/%h/1", k, s, y, y_valid, es[k], ey[k]);
      end
      checks++;
      if (din_ready !== er[k]) begin
        failures++;
        $display("FAIL rr_ready%0d got %b required %b", k, din_ready, er[k]);
      end
    end
    din_valid = 4'b0000;
    tick();
    checks++;
    if ({y_valid, s, y} !== {1'b0, 2'd0, 8'hA0}) begin
      failures++;
      $display("FAIL rr_drain yv=%b s=%0d y=%h required 0/0/a0", y_valid, s, y);
    end
  endtask

  task automatic test_single_channel;
    din = 32'h005A_0000; din_valid = 4'b0100; y_ready = 1'b1;
    #1;
    checks++;
    if (din_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready0 got %b required 0100", din_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({s, y, y_valid, din_ready} !== {2'd2, 8'h5A, 1'b1, 4'b0100}) begin
        failures++;
        $display("FAIL single%0d s=%0d y=%h yv=%b rdy=%b required 2/5a/1/0100", k, s, y, y_valid, din_ready);
      end
    end
    din_valid = 4'b0000;
    tick();
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain yv=%b required 0", y_valid);
    end
  endtask

  task automatic test_backpressure;
    din = 32'h0000_1100; din_valid = 4'b0010; y_ready = 1'b0;
    tick();
    checks++;
    if ({s, y, y_valid} !== {2'd1, 8'h11, 1'b1}) begin
      failures++;
      $display("FAIL bp_fill s=%0d y=%h yv=%b required 1/11/1", s, y, y_valid);
    end
    din = 32'h3C00_000C; din_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({s, y, y_valid, din_ready} !== {2'd1, 8'h11, 1'b1, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold%0d s=%0d y=%h yv=%b rdy=%b required 1/11/1/0000", k, s, y, y_valid, din_ready);
      end
      tick();
    end
    y_ready = 1'b1;
    #1;
    checks++;
    if ({s, din_ready} !== {2'd1, 4'b1000}) begin
      failures++;
      $display("FAIL bp_release s=%0d rdy=%b required 1/1000", s, din_ready);
    end
    tick();
    checks++;
    if ({s, y, y_valid, din_ready} !== {2'd3, 8'h3C, 1'b1, 4'b0001}) begin
      failures++;
      $display("FAIL bp_ch3 s=%0d y=%h yv=%b rdy=%b required 3/3c/1/0001", s, y, y_valid, din_ready);
    end
    tick();
    checks++;
    if ({s, y, y_valid} !== {2'd0, 8'h0C, 1'b1}) begin
      failures++;
      $display("FAIL bp_ch0 s=%0d y=%h yv=%b required 0/0c/1", s, y, y_valid);
    end
    din_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fairness;
    logic [3:0] vt [8] = '{4'b1011, 4'b1001, 4'b0011, 4'b1011, 4'b1011, 4'b1011, 4'b0001, 4'b1011};
    logic [1:0] es [8] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd1};
    logic [7:0] ey [8] = '{8'h10, 8'h30, 8'h00, 8'h11, 8'h31, 8'h01, 8'h02, 8'h12};
    int         seq [4] = '{0, 0, 0, 0};
    int         gap = 0;
    logic [3:0] hs;
    y_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_valid = vt[i];
      for (int k = 0; k < 4; k++) din[k*8 +: 8] = 8'(k*16 + seq[k]);
      @(negedge clk);
      hs = din_valid & din_ready;
      tick();
      for (int k = 0; k < 4; k++) if (hs[k]) seq[k]++;
      checks++;
      if ({s, y, y_valid} !== {es[i], ey[i], 1'b1}) begin
        failures++;
        $display("FAIL fair_word%0d s=%0d y=%h yv=%b required %0d/%h/1", i, s, y, y_valid, es[i], ey[i]);
      end
      gap = (s == 2'd0) ? 0 : gap + 1;
      checks++;
      if (gap > 3) begin
        failures++;
        $display("FAIL fair_starve%0d ch0 waited %0d grants, limit 3", i, gap);
      end
    end
    din_valid = 4'b0000;
    tick();
    checks++;
    if ({y_valid, seq[0], seq[1], seq[2], seq[3]} !== {1'b0, 32'd3, 32'd3, 32'd0, 32'd2}) begin
      failures++;
      $display("FAIL fair_count yv=%b hs=%0d/%0d/%0d/%0d required 0 and 3/3/0/2", y_valid, seq[0], seq[1], seq[2], seq[3]);
    end
  endtask

  task automatic test_reset_mid;
    din = 32'h0022_2100; din_valid = 4'b0110; y_ready = 1'b0;
    tick();
    checks++;
    if ({s, y, y_valid} !== {2'd2, 8'h22, 1'b1}) begin
      failures++;
      $display("FAIL mid_fill s=%0d y=%h yv=%b required 2/22/1", s, y, y_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y, s, y_valid, din_ready} !== {8'h00, 2'd0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL mid_async y=%h s=%0d yv=%b rdy=%b required 00/0/0/0000", y, s, y_valid, din_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (din_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_release_ready got %b required 0010", din_ready);
    end
    tick();
    checks++;
    if ({s, y, y_valid} !== {2'd1, 8'h21, 1'b1}) begin
      failures++;
      $display("FAIL mid_first_grant s=%0d y=%h yv=%b required 1/21/1", s, y, y_valid);
    end
    din_valid = 4'b0000; y_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_channel();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
